// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, one-hot result codes, chunk sizing.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional build macro used by the comparator: CMP_SIGNED_EN.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Result bits are ordered {equal, greater, smaller}.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int idx_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-bit unsigned magnitude comparator.
// Latency: 0 cycles. Backpressure: none (pure logic).
// Exactly one of eq/gt/lt is high for any input pair.
module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_seq_nb.sv
// Multi-cycle WIDTH-bit comparator, CHUNK bits per cycle MSB first, early exit on first differing chunk.
// Latency: 1..WIDTH/CHUNK cycles after the start edge. Backpressure: start ignored while busy.
// CMP_SIGNED_EN adds signed_mode for two's-complement ordering; default build is unsigned only.
import cmp_pkg::*;

module cmp_seq_nb #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             a_is_equal,
    output logic             a_is_greater,
    output logic             a_is_smaller
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = idx_width(WIDTH, CHUNK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
`ifdef CMP_SIGNED_EN
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
`endif

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [IDX_W-1:0]   idx;
    logic [2:0]         res_q;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic               c_eq;
    logic               c_gt;
    logic               c_lt;

    assign a_chunk = a_q[int'(idx)*CHUNK +: CHUNK];
    assign b_chunk = b_q[int'(idx)*CHUNK +: CHUNK];

    cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_cmp_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .eq (c_eq),
        .gt (c_gt),
        .lt (c_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            res_q <= RES_NONE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef CMP_SIGNED_EN
                        // Flipping both MSBs maps two's-complement order onto unsigned order.
                        a_q <= signed_mode ? (a ^ SIGN_MASK) : a;
                        b_q <= signed_mode ? (b ^ SIGN_MASK) : b;
`else
                        a_q <= a;
                        b_q <= b;
`endif
                        idx   <= IDX_LAST;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!c_eq) begin
                        res_q <= {1'b0, c_gt, c_lt};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (idx == '0) begin
                        res_q <= RES_EQ;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a_is_equal   = res_q[2];
    assign a_is_greater = res_q[1];
    assign a_is_smaller = res_q[0];

endmodule

// File: doc/cmp_seq_nb.md
# cmp_seq_nb

Parametrised, multi-cycle magnitude comparator: compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, terminating early on the first differing chunk. It is the sequential successor to the team's fixed 16-bit structural comparator. It is intended for wide operands where a single-cycle comparator would not close timing. Requests use a start/busy/done handshake, and the result is held until the next completion.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- signed_mode  input  1  two's-complement compare; sampled with start. Present only with CMP_SIGNED_EN.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse when a result is produced.
- a_is_equal  output  1  result: a == b.
- a_is_greater  output  1  result: a > b.
- a_is_smaller  output  1  result: a < b.

## Operation
- NCHUNK = WIDTH/CHUNK. The chunk index idx has width clog2(NCHUNK), minimum 1.
- States: IDLE, SCAN.
- IDLE with start=1:
  - latch a, b (and signed_mode) into internal registers;
  - set idx = NCHUNK-1;
  - busy←1; go to SCAN.
  - start=0 in IDLE: remain in IDLE.
- SCAN, each cycle: compare latched chunk [idx*CHUNK +: CHUNK] of A and B using the cmp_chunk instance.
  - Chunks differ: register the greater/smaller result, equal←0, done←1, busy←0, go to IDLE.
  - Chunks equal, idx==0: equal←1, greater←0, smaller←0, done←1, busy←0, go to IDLE.
  - Chunks equal, idx>0: idx←idx-1.
- Signed mode: the MSB of both latched operands is inverted before comparison, which maps two's complement onto unsigned order. Comparison is otherwise identical.
- Result outputs are one-hot after the first completion and change only on the completion edge.
- start while busy=1 is ignored: no queueing and no effect on the in-flight comparison.
- Input changes on a/b during SCAN have no effect, because the latched copies are used.

## Timing
- Reset values: state IDLE; busy=0, done=0, a_is_equal=0, a_is_greater=0, a_is_smaller=0; idx=0.
- Reset asserted mid-SCAN aborts the comparison immediately: no done, and results are cleared to 0.
- Let the start edge be E0, and k be the number of equal leading chunks (0 ≤ k ≤ NCHUNK-1), or k=NCHUNK-1 when the operands are fully equal.
  - Completion edge is E(k+1); done is high for exactly the cycle after E(k+1).
  - Best-case latency is 1 cycle. Worst case (equal operands, or difference only in the LS chunk) is NCHUNK cycles.
- busy is high from E0 through E(k+1), and low in the done cycle.
- Back-to-back: start=1 in the done cycle is accepted (state is IDLE). Results from the previous operation stay valid until the new completion edge.
- Throughput is at most one comparison per k+1 cycles.

## Configuration
- CMP_SIGNED_EN defined:
  - signed_mode port exists;
  - signed_mode=1 selects two's-complement ordering, and signed_mode=0 selects unsigned ordering.
- CMP_SIGNED_EN undefined:
  - no signed_mode port and no sign-flip logic;
  - the comparison is always unsigned.

## Structure
- Shared package cmp_pkg:
  - state encoding typedef (IDLE, SCAN);
  - result encoding constants (EQ, GT, LT);
  - function computing NCHUNK / idx width.
- Sub-module cmp_chunk: combinational CHUNK-bit comparator with outputs eq, gt, lt. Instantiated once, fed by the idx-selected slice.
- The top level holds the FSM, operand registers, idx counter and result registers.

## Test plan
All cases use WIDTH=16, CHUNK=4.
- a=0x1234, b=0x1234, start pulse → done 4 cycles after start edge; equal=1, greater=0, smaller=0; busy high for cycles 1–4 only.
- a=0x8000, b=0x7FFF, unsigned → done after 1 cycle, greater=1. With CMP_SIGNED_EN and signed_mode=1 → done after 1 cycle, smaller=1.
- a=0x1235, b=0x1234; second start with a=0 asserted at cycle 2 → ignored; done after 4 cycles, greater=1; no second done.
- a=0x0100, b=0x0200 → done after 2 cycles, smaller=1. Change a to 0xFFFF during SCAN → result unaffected.
- Start a=0x0001, b=0x0001, then assert rst at cycle 2 → busy=0, done never pulses, all result outputs 0. After release, a=5, b=3 → greater=1 after 4 cycles.
- Back-to-back: start a=0xF000, b=0x0000 (done after 1 cycle), then start a=0, b=1 in the done cycle → accepted; done after 4 cycles, smaller=1; greater held 1 until that edge.
